// File: rtl/hazard_ctl.sv
// Decode-stage hazard controller: freezes PC/IF-ID and bubbles ID/EXE when
// forwarding cannot cover a dependency, applies branch flushes, and keeps
// saturating stall statistics.

`ifndef FLD_REGNUM_SIZE
`define FLD_REGNUM_SIZE 5
`endif
`ifndef RESULT_FWD_NONE
`define RESULT_FWD_NONE 2'd0
`endif
`ifndef RESULT_FWD_MEM
`define RESULT_FWD_MEM 2'd1
`endif
`ifndef RESULT_FWD_WB
`define RESULT_FWD_WB 2'd2
`endif

module hazard_ctl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enabled,
  input  logic                        id_Valid,
  input  logic [`FLD_REGNUM_SIZE-1:0] id_Arg1,
  input  logic [`FLD_REGNUM_SIZE-1:0] id_Arg2,
  input  logic                        id_Arg1Used,
  input  logic                        id_Arg2Used,
  input  logic [`FLD_REGNUM_SIZE-1:0] exe_DstReg,
  input  logic [`FLD_REGNUM_SIZE-1:0] mem_DstReg,
  input  logic [1:0]                  exe_FwdStage,
  input  logic [1:0]                  mem_FwdStage,
  input  logic                        exe_BranchTaken,
  output logic                        pc_Hold,
  output logic                        ifid_Hold,
  output logic                        idexe_Bubble,
  output logic                        ifid_Flush,
  output logic                        idexe_Flush,
  output logic                        busy,
  output logic [CNT_W-1:0]            stallCycles,
  output logic [CNT_W-1:0]            stallEvents
);

  localparam int unsigned REG_W = `FLD_REGNUM_SIZE;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t     state, nextState;
  logic [1:0] cnt, nextCnt;
  logic [1:0] need1, need2, needMax;
  logic       hold, newEvent, flush;

  // Stall cycles demanded by one source operand (EXE match beats MEM match)
  function automatic logic [1:0] srcStall(input logic [REG_W-1:0] arg, input logic used);
    logic exeHit, memHit;
    exeHit = id_Valid && used && (arg != '0) && (arg == exe_DstReg) &&
             (exe_FwdStage != `RESULT_FWD_NONE);
    memHit = id_Valid && used && (arg != '0) && (arg == mem_DstReg) &&
             (mem_FwdStage != `RESULT_FWD_NONE);
    if (enabled) begin
      srcStall = (exeHit && exe_FwdStage == `RESULT_FWD_WB) ? 2'd1 : 2'd0;
    end else if (exeHit) begin
      srcStall = 2'd2;
    end else if (memHit) begin
      srcStall = 2'd1;
    end else begin
      srcStall = 2'd0;
    end
  endfunction

  // Per-source requirement and the larger of the two
  always_comb begin
    need1   = srcStall(id_Arg1, id_Arg1Used);
    need2   = srcStall(id_Arg2, id_Arg2Used);
    needMax = (need1 > need2) ? need1 : need2;
  end

  // Next-state and hold/flush decode; flush overrides any stall
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    hold      = 1'b0;
    newEvent  = 1'b0;
    flush     = 1'b0;
    if (rst) begin
      nextState = IDLE;
      nextCnt   = 2'd0;
    end else if (exe_BranchTaken) begin
      flush     = 1'b1;
      nextState = IDLE;
      nextCnt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (needMax != 2'd0) begin
            hold     = 1'b1;
            newEvent = 1'b1;
            if (needMax == 2'd2) begin
              nextState = STALL;
              nextCnt   = 2'd1;
            end
          end
        end
        STALL: begin
          hold = 1'b1;
          if (cnt == 2'd1) begin
            nextState = IDLE;
            nextCnt   = 2'd0;
          end else begin
            nextCnt = cnt - 2'd1;
          end
        end
        default: begin
          nextState = IDLE;
          nextCnt   = 2'd0;
        end
      endcase
    end
  end

  // Output fan-out; everything is quiet while reset is held
  always_comb begin
    pc_Hold      = hold;
    ifid_Hold    = hold;
    idexe_Bubble = hold;
    ifid_Flush   = flush;
    idexe_Flush  = flush;
    busy         = !rst && (state == STALL);
  end

  // State register and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      stallCycles <= '0;
      stallEvents <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (hold && stallCycles != CNT_MAX) stallCycles <= stallCycles + CNT_W'(1);
      if (newEvent && stallEvents != CNT_MAX) stallEvents <= stallEvents + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard/stall controller sitting in the decode (ID) stage, the producer-side companion of the forwarding unit. It compares the source registers of the instruction in ID against the destinations and forwarding flags (`RESULT_FWD_NONE/MEM/WB`) of the instructions in EXE and MEM. When the forwarding unit cannot supply an operand in time, it freezes PC and IF/ID and injects bubbles into ID/EXE for the required number of cycles. It also applies branch flushes and keeps saturating stall statistics.

## Interface
- CNT_W, 16, width of the performance counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enabled  in  1  forwarding unit enabled; same signal that drives the forwarding unit.
- id_Valid  in  1  ID holds a real instruction. When 0, no hazard is detected.
- id_Arg1, id_Arg2  in  `FLD_REGNUM_SIZE  source register numbers of the ID instruction.
- id_Arg1Used, id_Arg2Used  in  1  the source is actually read. Immediate operands drive 0 here.
- exe_DstReg, mem_DstReg  in  `FLD_REGNUM_SIZE  destination registers of the EXE and MEM instructions.
- exe_FwdStage, mem_FwdStage  in  2  forwarding flags of the EXE and MEM instructions. `RESULT_FWD_NONE` means no register write.
- exe_BranchTaken  in  1  the branch in EXE resolved taken.
- pc_Hold  out  1  PC keeps its value.
- ifid_Hold  out  1  IF/ID register keeps its value.
- idexe_Bubble  out  1  ID/EXE loads a NOP (all control zero, FwdStage `RESULT_FWD_NONE`).
- ifid_Flush, idexe_Flush  out  1  the register loads a NOP.
- busy  out  1  FSM is in STALL.
- stallCycles  out  CNT_W  count of cycles with pc_Hold=1, saturating.
- stallEvents  out  CNT_W  count of new stalls started, saturating.

## Operation
**Match rule.** Source s matches stage X when all of the following hold:
- id_Valid=1;
- idArgNUsed=1;
- idArgN == X_DstReg;
- idArgN != 0 (register $0 never matches);
- X_FwdStage != `RESULT_FWD_NONE`.

**Required stall length per source, N(s).** The register file is write-before-read, so an instruction in WB needs no stall.
- enabled=1:
  - EXE match with `RESULT_FWD_WB` (load-use) gives 1.
  - EXE match with `RESULT_FWD_MEM` gives 0.
  - Any MEM match gives 0.
- enabled=0:
  - EXE match gives 2.
  - Otherwise a MEM match gives 1.
  - Otherwise 0.
- An EXE match takes precedence over a MEM match for the same source.
- N = max(N(arg1), N(arg2)).

**FSM states:** IDLE and STALL, with a 2-bit down counter `cnt`.
- IDLE, N=0: all hold/bubble outputs are 0.
- IDLE, N≥1 (new stall):
  - pc_Hold=ifid_Hold=idexe_Bubble=1 combinationally in the same cycle.
  - stallEvents increments.
  - If N=2: next state STALL, cnt←1. If N=1: stay in IDLE.
- STALL:
  - pc_Hold=ifid_Hold=idexe_Bubble=busy=1, independent of the match inputs.
  - cnt=1 → next state IDLE, cnt←0.
  - Otherwise cnt←cnt−1 (reserved for longer sequences).
- IDLE re-evaluates every cycle. A stall that does not clear is re-detected as a new event. This is legal but indicates a bench error for a well-formed pipeline.

**Flush.**
- exe_BranchTaken=1 gives ifid_Flush=idexe_Flush=1 in that cycle.
- In the same cycle pc_Hold, ifid_Hold and idexe_Bubble are forced to 0, so the branch target is fetched.
- The FSM goes to IDLE with cnt←0, aborting any stall in progress.
- No new stall event is counted that cycle.

**Counters.**
- stallCycles increments in each cycle with pc_Hold=1.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset (rst=1 at an edge): state IDLE, cnt=0, stallCycles=0, stallEvents=0.
- While rst=1, every combinational output is also forced to 0.
- Hazard-to-stall latency: 0 cycles (combinational in IDLE). Exit from STALL is registered.
- Total stall cycles for one hazard equals N: 1 for load-use; 2 or 1 with forwarding disabled.
- Reset asserted mid-STALL: the next edge returns to IDLE, with outputs 0 during reset.
- Branch plus hazard in the same cycle: the flush wins, and stall outputs are 0.
- Both sources hazard with different N: the larger N applies.
- The bubble inserted carries `RESULT_FWD_NONE`. The next IDLE evaluation therefore sees no EXE match from it.

## Test plan
- **Load-use, forwarding on.**
  - Stimulus: enabled=1, EXE dst=5 with `RESULT_FWD_WB`; ID arg1=5, used.
  - Required: pc_Hold/idexe_Bubble high for exactly 1 cycle; stallEvents=1; stallCycles=1.
  - Then present MEM dst=5 with `RESULT_FWD_WB`: no stall.
- **ALU result, forwarding on.**
  - Stimulus: EXE dst=7 with `RESULT_FWD_MEM`; ID arg2=7, used.
  - Required: no stall.
  - Repeat with arg2Used=0, and separately with arg=0 and dst=0: no stall.
- **Forwarding off.**
  - Stimulus: enabled=0, EXE dst=3 with `RESULT_FWD_MEM`; ID arg1=3.
  - Required: 2 stall cycles, with busy=1 in the second; stallEvents+1, stallCycles+2.
  - Variant: MEM-only match gives 1 cycle.
- **Branch abort.**
  - Stimulus: enter STALL (forwarding off, EXE match), then exe_BranchTaken=1 in the second stall cycle.
  - Required: in that cycle both flushes=1 and hold/bubble=0; the next cycle is IDLE.
- **Reset mid-stall.**
  - Stimulus: rst=1 while busy=1.
  - Required: outputs 0 during reset; after reset, state IDLE and both counters 0.
- **Saturation.**
  - Stimulus: CNT_W=4, 20 consecutive load-use hazards.
  - Required: stallEvents=stallCycles=15, held at 15.
